// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Brief    : Asynchronous serial receiver with mid-bit sampling, a
//             valid/ready holding register and framing/parity/overrun flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic [CNT_W-1:0]       cnt;
    logic                   tick;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bad;
    logic                   stop_bad;
    logic                   commit;
    logic                   consume;

    assign rs      = sync_q[SYNC_STAGES-1];
    assign busy    = (state != S_IDLE);
    assign consume = rx_valid && rx_ready;

    // Metastability synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    // Sample strobe: half a bit into the start bit, then every full bit.
    always_comb begin
        tick = 1'b0;
        if (state == S_START) begin
            tick = (cnt == CNT_HALF);
        end else begin
            tick = (cnt == CNT_FULL);
        end
    end

    // Bit-period counter, held at zero while idle and reloaded on each sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_IDLE || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a good stop bit returns straight to IDLE so that a
    // back-to-back start edge is caught immediately.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (!rs) state_next = S_START;
            S_START:    if (tick) state_next = rs ? S_IDLE : S_DATA;
            S_DATA:     if (tick && bit_idx == IDX_LAST)
                            state_next = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY:   if (tick) state_next = S_STOP;
            S_STOP:     if (tick) state_next = rs ? S_IDLE : S_BRK_WAIT;
            S_BRK_WAIT: if (rs) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Frame datapath: LSB-first shift, parity check, stop check, commit pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx  <= '0;
            shift_q  <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            commit   <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (state == S_START) begin
                bit_idx <= '0;
                par_bad <= 1'b0;
            end
            if (state == S_DATA && tick) begin
                shift_q <= {rs, shift_q[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == S_PARITY && tick) begin
                par_bad <= rs ^ (^shift_q) ^ PAR_ODD;
            end
            if (state == S_STOP && tick) begin
                stop_bad <= ~rs;
                commit   <= 1'b1;
            end
        end
    end

    // Holding register: a commit wins when the slot is free or being drained,
    // otherwise the frame is dropped and overrun sticks until the next consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            if (!rx_valid || rx_ready) begin
                rx_data    <= shift_q;
                frame_err  <= stop_bad;
                parity_err <= par_bad;
                rx_valid   <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (consume) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Brief    : Self-checking bench for uart_rx_core: directed scenarios plus
//             randomized frames with bit-period jitter, scored against a
//             frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CLKS_PER_BIT = 16;
    localparam int DATA_BITS    = 8;
    localparam int SYNC_STAGES  = 2;
    localparam int CLK_NS       = 10;
    localparam int BIT_NS       = CLKS_PER_BIT * CLK_NS;
    // Cycles from the first in-FSM low sample to rx_valid, without / with parity.
    localparam int LAT_NP = CLKS_PER_BIT / 2 + (DATA_BITS + 1) * CLKS_PER_BIT + 1;
    localparam int LAT_P  = CLKS_PER_BIT / 2 + (DATA_BITS + 2) * CLKS_PER_BIT + 1;

    logic       clk = 1'b0;
    logic       rst, rxd, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;
    logic       rst_p, rxd_p, rx_ready_p;
    logic [7:0] rx_data_p;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx_core u_dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
        .clk(clk), .rst(rst_p), .rxd(rxd_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_ready(rx_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overrun(overrun_p), .busy(busy_p)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference model: what a correct receiver reports for a frame.
    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rx_exp_t;

    rx_exp_t exp_q[$];
    int      n_rx = 0;

    function automatic rx_exp_t model_frame(input logic [7:0] data, input bit has_par,
                                            input logic par_bit, input logic stop_bit);
        rx_exp_t e;
        e.data = data;
        e.ferr = ~stop_bit;
        e.perr = has_par ? (par_bit != ^data) : 1'b0;
        return e;
    endfunction

    // Scoreboard on the default instance: every accepted byte must match the model.
    always @(negedge clk) begin : mon_default
        rx_exp_t e;
        if (!rst && rx_valid && rx_ready) begin
            n_rx++;
            check_val("mon_frame_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("mon_data", rx_data, e.data);
                check_val("mon_frame_err", frame_err, e.ferr);
                check_val("mon_parity_err", parity_err, e.perr);
            end
        end
    end

    task automatic drive_line(input bit sel, input logic v);
        if (sel) rxd_p = v;
        else     rxd   = v;
    endtask

    // Line is left at the stop-bit level afterwards.
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input logic stop_bit, input int per_ns);
        drive_line(sel, 1'b0);
        #(per_ns);
        for (int i = 0; i < DATA_BITS; i++) begin
            drive_line(sel, data[i]);
            #(per_ns);
        end
        if (has_par) begin
            drive_line(sel, par_bit);
            #(per_ns);
        end
        drive_line(sel, stop_bit);
        #(per_ns);
    endtask

    task automatic wait_valid(input bit sel, input int max_cyc, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < max_cyc) begin
            @(posedge clk);
            #1;
            cycles++;
            seen = sel ? rx_valid_p : rx_valid;
        end
    endtask

    // Time bound for the whole run.
    initial begin
        #2ms;
        n_fail++;
        $display("FAIL watchdog: run did not complete within 2 ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int      cyc;
        bit      seen;
        int      rx_before;
        logic    pb;
        logic [7:0] b;
        int      per;

        rst = 1'b1; rst_p = 1'b1; rxd = 1'b1; rxd_p = 1'b1;
        rx_ready = 1'b1; rx_ready_p = 1'b1;
        #23;
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_errs", {frame_err, parity_err, overrun}, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_p_outputs", {rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p}, 0);
        @(negedge clk);
        rst = 1'b0; rst_p = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        // Single frame: value, flags, one-cycle pulse and latency from the pin edge.
        exp_q.push_back(model_frame(8'hA5, 0, 1'b0, 1'b1));
        fork
            send_frame(0, 8'hA5, 0, 1'b0, 1'b1, BIT_NS);
            wait_valid(0, 400, cyc, seen);
        join_any
        check_val("t1_seen", seen, 1);
        check_val($sformatf("t1_latency_cyc%0d", cyc),
                  32'(cyc >= LAT_NP + SYNC_STAGES - 1 && cyc <= LAT_NP + SYNC_STAGES + 1), 1);
        check_val("t1_data", rx_data, 8'hA5);
        check_val("t1_flags", {frame_err, parity_err, overrun}, 0);
        @(posedge clk);
        #1;
        check_val("t1_pulse_width", rx_valid, 0);
        wait fork;
        repeat (10) @(posedge clk);

        // Back-to-back frames with no idle gap.
        exp_q.push_back(model_frame(8'h00, 0, 1'b0, 1'b1));
        exp_q.push_back(model_frame(8'hFF, 0, 1'b0, 1'b1));
        exp_q.push_back(model_frame(8'h55, 0, 1'b0, 1'b1));
        fork
            begin
                send_frame(0, 8'h00, 0, 1'b0, 1'b1, BIT_NS);
                send_frame(0, 8'hFF, 0, 1'b0, 1'b1, BIT_NS);
                send_frame(0, 8'h55, 0, 1'b0, 1'b1, BIT_NS);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    #(5 * BIT_NS);
                    check_val("t2_busy_mid_frame", busy, 1);
                    #(5 * BIT_NS - 1);
                    check_val("t2_busy_between", busy, 0);
                    #1;
                end
            end
        join
        repeat (10) @(posedge clk);
        check_val("t2_all_received", exp_q.size(), 0);

        // Glitch shorter than half a bit must be rejected.
        rx_before = n_rx;
        rxd = 1'b0;
        #(4 * CLK_NS);
        rxd = 1'b1;
        #1;
        check_val("t3_busy_during_glitch", busy, 1);
        repeat (12) @(posedge clk);
        #1;
        check_val("t3_busy_after_glitch", busy, 0);
        check_val("t3_no_valid", n_rx, rx_before);
        exp_q.push_back(model_frame(8'h3C, 0, 1'b0, 1'b1));
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, BIT_NS);
        repeat (10) @(posedge clk);
        check_val("t3_frame_after_glitch", exp_q.size(), 0);

        // Bad stop bit followed by a held-low line: exactly one errored frame.
        rx_before = n_rx;
        exp_q.push_back(model_frame(8'h3C, 0, 1'b0, 1'b0));
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, BIT_NS);
        #(40 * CLK_NS);
        check_val("t4_one_frame", n_rx, rx_before + 1);
        check_val("t4_data_held", rx_data, 8'h3C);
        check_val("t4_frame_err", frame_err, 1);
        check_val("t4_busy_in_break", busy, 1);
        rxd = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("t4_idle_after_break", busy, 0);
        check_val("t4_still_one_frame", n_rx, rx_before + 1);
        exp_q.push_back(model_frame(8'h81, 0, 1'b0, 1'b1));
        send_frame(0, 8'h81, 0, 1'b0, 1'b1, BIT_NS);
        repeat (10) @(posedge clk);
        #1;
        check_val("t4_next_frame", exp_q.size(), 0);
        check_val("t4_next_frame_err", frame_err, 0);

        // Overrun: second frame dropped while the first is unconsumed.
        rx_ready = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1, BIT_NS);
        repeat (10) @(posedge clk);
        #1;
        check_val("t5_valid_held", rx_valid, 1);
        check_val("t5_data_first", rx_data, 8'h11);
        check_val("t5_overrun", overrun, 1);
        exp_q.push_back(model_frame(8'h11, 0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check_val("t5_valid_cleared", rx_valid, 0);
        check_val("t5_overrun_cleared", overrun, 0);
        check_val("t5_one_consumed", exp_q.size(), 0);
        rx_ready = 1'b1;
        exp_q.push_back(model_frame(8'h33, 0, 1'b0, 1'b1));
        send_frame(0, 8'h33, 0, 1'b0, 1'b1, BIT_NS);
        repeat (10) @(posedge clk);
        #1;
        check_val("t5_data_after", rx_data, 8'h33);
        check_val("t5_drained", exp_q.size(), 0);

        // Even parity instance: correct parity, wrong parity, reset mid-frame.
        pb = ^8'h07;
        fork
            send_frame(1, 8'h07, 1, pb, 1'b1, BIT_NS);
            wait_valid(1, 400, cyc, seen);
        join
        check_val("t6_seen_good", seen, 1);
        check_val($sformatf("t6_latency_cyc%0d", cyc),
                  32'(cyc >= LAT_P + SYNC_STAGES - 1 && cyc <= LAT_P + SYNC_STAGES + 1), 1);
        check_val("t6_data_good", rx_data_p, 8'h07);
        check_val("t6_perr_good", parity_err_p, model_frame(8'h07, 1, pb, 1'b1).perr);
        check_val("t6_ferr_good", frame_err_p, 0);
        #(2 * BIT_NS);
        fork
            send_frame(1, 8'h07, 1, ~pb, 1'b1, BIT_NS);
            wait_valid(1, 400, cyc, seen);
        join
        check_val("t6_seen_bad", seen, 1);
        check_val("t6_data_bad", rx_data_p, 8'h07);
        check_val("t6_perr_bad", parity_err_p, model_frame(8'h07, 1, ~pb, 1'b1).perr);
        #(2 * BIT_NS);
        fork
            send_frame(1, 8'hC3, 1, ^8'hC3, 1'b1, BIT_NS);
            begin
                #(BIT_NS + 3 * BIT_NS + BIT_NS / 2);
                rst_p = 1'b1;
                #1;
                check_val("t6_rst_data", rx_data_p, 0);
                check_val("t6_rst_flags",
                          {rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p}, 0);
            end
        join
        #(BIT_NS);
        @(negedge clk);
        rst_p = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("t6_no_partial_frame", {rx_valid_p, busy_p}, 0);
        pb = ^8'h5A;
        fork
            send_frame(1, 8'h5A, 1, pb, 1'b1, BIT_NS);
            wait_valid(1, 400, cyc, seen);
        join
        check_val("t6_seen_after_rst", seen, 1);
        check_val("t6_data_after_rst", rx_data_p, 8'h5A);
        check_val("t6_perr_after_rst", parity_err_p, 0);

        // Random bytes, sender bit period within +/-3%, random idle gaps.
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            per = BIT_NS - 4 + int'($urandom_range(0, 8));
            exp_q.push_back(model_frame(b, 0, 1'b0, 1'b1));
            send_frame(0, b, 0, 1'b0, 1'b1, per);
            #($urandom_range(0, 400));
        end
        repeat (20) @(posedge clk);
        check_val("t7_random_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
